// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for a 5-stage RISC-V pipeline.
// Shadows EX/MEM/WB destination tags; drives EX operand mux selects and the ID stall.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int RF_BYPASS  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_memwrite,
  input  logic                  flush,
  output logic                  id_stall,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [1:0]            fwd_wd_sel,
  output logic [CNT_W-1:0]      stall_count
);

  typedef logic [REG_ADDR_W-1:0] reg_t;

  typedef struct packed {
    logic valid;
    reg_t rs1;
    reg_t rs2;
    logic uses1;
    logic uses2;
    reg_t rd;
    logic regwrite;
    logic memread;
    logic memwrite;
  } ex_t;

  typedef struct packed {
    logic valid;
    reg_t rd;
    logic regwrite;
    logic memread;
  } mem_t;

  typedef struct packed {
    logic valid;
    reg_t rd;
    logic regwrite;
  } wb_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ex_t              ex_q, ex_d;
  mem_t             mem_q, mem_d;
  wb_t              wb_q, wb_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  function automatic logic ex_hit(input ex_t e, input reg_t r);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == r);
  endfunction

  function automatic logic mem_hit(input mem_t m, input reg_t r);
    return m.valid && m.regwrite && (m.rd != '0) && (m.rd == r);
  endfunction

  function automatic logic wb_hit(input wb_t w, input reg_t r);
    return w.valid && w.regwrite && (w.rd != '0) && (w.rd == r);
  endfunction

  // Nearer stage wins; a load still in MEM has no data yet, so it never feeds 10.
  function automatic logic [1:0] fwd_sel(input logic active, input reg_t r,
                                         input mem_t m, input wb_t w);
    if (!active) return 2'b00;
    if (mem_hit(m, r) && !m.memread) return 2'b10;
    if (wb_hit(w, r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic src_hazard(input logic uses, input reg_t r, input ex_t e,
                                      input mem_t m, input wb_t w);
    if (!uses || (r == '0)) return 1'b0;
    if (FWD_EN != 0) return ex_hit(e, r) && e.memread;
    return ex_hit(e, r) || mem_hit(m, r) || ((RF_BYPASS == 0) && wb_hit(w, r));
  endfunction

  always_comb begin
    id_stall   = id_valid && !flush &&
                 (src_hazard(id_uses_rs1, id_rs1, ex_q, mem_q, wb_q) ||
                  src_hazard(id_uses_rs2, id_rs2, ex_q, mem_q, wb_q));
    fwd_a_sel  = fwd_sel((FWD_EN != 0) && ex_q.valid && ex_q.uses1,
                         ex_q.rs1, mem_q, wb_q);
    fwd_b_sel  = fwd_sel((FWD_EN != 0) && ex_q.valid && ex_q.uses2 && !ex_q.memwrite,
                         ex_q.rs2, mem_q, wb_q);
    fwd_wd_sel = fwd_sel((FWD_EN != 0) && ex_q.valid && ex_q.uses2 && ex_q.memwrite,
                         ex_q.rs2, mem_q, wb_q);
  end

  always_comb begin
    ex_d = '0;
    if (!id_stall && !flush) begin
      ex_d.valid    = id_valid;
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      ex_d.uses1    = id_uses_rs1;
      ex_d.uses2    = id_uses_rs2;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.memwrite = id_memwrite;
    end

    mem_d.valid    = ex_q.valid;
    mem_d.rd       = ex_q.rd;
    mem_d.regwrite = ex_q.regwrite;
    mem_d.memread  = ex_q.memread;

    wb_d.valid    = mem_q.valid;
    wb_d.rd       = mem_q.rd;
    wb_d.regwrite = mem_q.regwrite;

    stall_count_d = stall_count_q;
    if (id_stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
